// File: rtl/rram_read_sequencer_if.sv
// ---------------------------------------------------------------------------
// rram_read_sequencer_if
// Command and result handshake between the RRAM controller and the read
// sequencer.
//   start / mode / wl_sel : read request, sampled by the sequencer in IDLE
//   busy / cmd_err        : sequencer status, rejected-command pulse
//   result / result_mode / result_valid / result_ready : result handshake
// master = controller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface rram_read_sequencer_if;
    logic        start;
    logic        mode;
    logic [15:0] wl_sel;
    logic        busy;
    logic        cmd_err;
    logic [47:0] result;
    logic        result_mode;
    logic        result_valid;
    logic        result_ready;

    modport master (
        output start, mode, wl_sel, result_ready,
        input  busy, cmd_err, result, result_mode, result_valid
    );

    modport slave (
        input  start, mode, wl_sel, result_ready,
        output busy, cmd_err, result, result_mode, result_valid
    );
endinterface

// File: rtl/rram_read_sequencer.sv
// ---------------------------------------------------------------------------
// rram_read_sequencer
// Runs one read of the RRAM analog macro: bitline precharge, wordline /
// bitline / sourceline drive, CSA sense or 3-bit ADC conversion, then result
// capture. The captured result is offered through a valid/ready handshake.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   cmd               : command/result handshake (slave modport)
//   ENABLE_WL/BL/SL   : line driver enables
//   IN0_WL, IN1_WL    : wordline select / level select (level always 0)
//   PRE               : bitline precharge
//   ENABLE_CSA, SAEN_CSA : CSA bank enable, sense-amp enable
//   CLK_EN_ADC        : ADC clock-enable phases
//   CSA, ADC_OUT0..2  : sensed data from the macro
// All macro-side and status outputs come straight from flops whose next value
// is derived from the next FSM state, so they line up with the state and are
// glitch-free.
// ---------------------------------------------------------------------------
module rram_read_sequencer #(
    parameter int unsigned PRE_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned SAEN_CYCLES   = 2,
    parameter int unsigned ADC_CYCLES    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    rram_read_sequencer_if.slave        cmd,
    output logic                        ENABLE_WL,
    output logic                        ENABLE_BL,
    output logic                        ENABLE_SL,
    output logic [15:0]                 IN0_WL,
    output logic [15:0]                 IN1_WL,
    output logic                        PRE,
    output logic                        ENABLE_CSA,
    output logic                        SAEN_CSA,
    output logic [1:0]                  CLK_EN_ADC,
    input  logic [15:0]                 CSA,
    input  logic [15:0]                 ADC_OUT0,
    input  logic [15:0]                 ADC_OUT1,
    input  logic [15:0]                 ADC_OUT2
);

    // Counter reload values: a state lasting N cycles loads N-1; 0 acts as 1.
    localparam logic [7:0] PRE_LOAD    = (PRE_CYCLES    == 0) ? 8'd0 : 8'(PRE_CYCLES    - 1);
    localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SAEN_LOAD   = (SAEN_CYCLES   == 0) ? 8'd0 : 8'(SAEN_CYCLES   - 1);
    localparam logic [7:0] ADC_LOAD    = (ADC_CYCLES    == 0) ? 8'd0 : 8'(ADC_CYCLES    - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_DRIVE     = 3'd2,
        ST_SENSE     = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        adc_phase_q, adc_phase_d;   // 0: first ADC phase, 1: second
    logic        mode_q, mode_d;
    logic [15:0] wl_sel_q, wl_sel_d;
    logic [47:0] result_q, result_d;
    logic        result_mode_q, result_mode_d;

    logic        pre_q, pre_d;
    logic        en_drv_q, en_drv_d;
    logic [15:0] in0_wl_q, in0_wl_d;
    logic        en_csa_q, en_csa_d;
    logic        saen_q, saen_d;
    logic [1:0]  clk_en_adc_q, clk_en_adc_d;
    logic        busy_q, busy_d;
    logic        cmd_err_q, cmd_err_d;
    logic        result_valid_q, result_valid_d;

    // Next-state, state timer and data capture.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        adc_phase_d   = adc_phase_q;
        mode_d        = mode_q;
        wl_sel_d      = wl_sel_q;
        result_d      = result_q;
        result_mode_d = result_mode_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd.start && (cmd.wl_sel != 16'h0000)) begin
                    state_d  = ST_PRECHARGE;
                    cnt_d    = PRE_LOAD;
                    mode_d   = cmd.mode;
                    wl_sel_d = cmd.wl_sel;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PRECHARGE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DRIVE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 8'd0) begin
                    state_d     = ST_SENSE;
                    cnt_d       = mode_q ? ADC_LOAD : SAEN_LOAD;
                    adc_phase_d = 1'b0;
                end else begin
                    cnt_d       = cnt_q - 8'd1;
                end
            end
            ST_SENSE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (mode_q && !adc_phase_q) begin
                    // ADC conversion runs a second phase of equal length.
                    adc_phase_d = 1'b1;
                    cnt_d       = ADC_LOAD;
                end else begin
                    state_d     = ST_CAPTURE;
                    cnt_d       = 8'd0;
                end
            end
            ST_CAPTURE: begin
                state_d       = ST_HOLD;
                result_d      = mode_q ? {ADC_OUT2, ADC_OUT1, ADC_OUT0} : {32'h0000_0000, CSA};
                result_mode_d = mode_q;
            end
            ST_HOLD: begin
                if (cmd.result_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        pre_d          = (state_d == ST_PRECHARGE);
        en_drv_d       = (state_d == ST_DRIVE) || (state_d == ST_SENSE) || (state_d == ST_CAPTURE);
        in0_wl_d       = en_drv_d ? wl_sel_d : 16'h0000;
        en_csa_d       = !mode_d && ((state_d == ST_SENSE) || (state_d == ST_CAPTURE));
        saen_d         = !mode_d && (state_d == ST_SENSE);
        clk_en_adc_d   = (mode_d && (state_d == ST_SENSE)) ? (adc_phase_d ? 2'b10 : 2'b01) : 2'b00;
        busy_d         = (state_d != ST_IDLE);
        cmd_err_d      = (state_q == ST_IDLE) && cmd.start && (cmd.wl_sel == 16'h0000);
        result_valid_d = (state_d == ST_HOLD);
    end

    // FSM state, timer and latched command/result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            adc_phase_q   <= 1'b0;
            mode_q        <= 1'b0;
            wl_sel_q      <= 16'h0000;
            result_q      <= 48'h0;
            result_mode_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            adc_phase_q   <= adc_phase_d;
            mode_q        <= mode_d;
            wl_sel_q      <= wl_sel_d;
            result_q      <= result_d;
            result_mode_q <= result_mode_d;
        end
    end

    // Registered macro and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q          <= 1'b0;
            en_drv_q       <= 1'b0;
            in0_wl_q       <= 16'h0000;
            en_csa_q       <= 1'b0;
            saen_q         <= 1'b0;
            clk_en_adc_q   <= 2'b00;
            busy_q         <= 1'b0;
            cmd_err_q      <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            en_drv_q       <= en_drv_d;
            in0_wl_q       <= in0_wl_d;
            en_csa_q       <= en_csa_d;
            saen_q         <= saen_d;
            clk_en_adc_q   <= clk_en_adc_d;
            busy_q         <= busy_d;
            cmd_err_q      <= cmd_err_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign PRE              = pre_q;
    assign ENABLE_WL        = en_drv_q;
    assign ENABLE_BL        = en_drv_q;
    assign ENABLE_SL        = en_drv_q;
    assign IN0_WL           = in0_wl_q;
    assign IN1_WL           = 16'h0000;   // reads never select a wordline level
    assign ENABLE_CSA       = en_csa_q;
    assign SAEN_CSA         = saen_q;
    assign CLK_EN_ADC       = clk_en_adc_q;
    assign cmd.busy         = busy_q;
    assign cmd.cmd_err      = cmd_err_q;
    assign cmd.result       = result_q;
    assign cmd.result_mode  = result_mode_q;
    assign cmd.result_valid = result_valid_q;

endmodule

// File: tb/tb_rram_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rram_read_sequencer
// Directed bench. Each accepted read pushes its expected result, mode and
// first-valid cycle into a queue; a separate monitor pops and compares when
// result_valid rises. The main thread also checks macro pin timing.
// ---------------------------------------------------------------------------
module tb_rram_read_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ENABLE_WL, ENABLE_BL, ENABLE_SL, PRE, ENABLE_CSA, SAEN_CSA;
    logic [15:0] IN0_WL, IN1_WL;
    logic [1:0]  CLK_EN_ADC;
    logic [15:0] CSA = 16'h0000;
    logic [15:0] ADC_OUT0 = 16'h0000;
    logic [15:0] ADC_OUT1 = 16'h0000;
    logic [15:0] ADC_OUT2 = 16'h0000;

    rram_read_sequencer_if bus ();

    rram_read_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus),
        .ENABLE_WL  (ENABLE_WL),
        .ENABLE_BL  (ENABLE_BL),
        .ENABLE_SL  (ENABLE_SL),
        .IN0_WL     (IN0_WL),
        .IN1_WL     (IN1_WL),
        .PRE        (PRE),
        .ENABLE_CSA (ENABLE_CSA),
        .SAEN_CSA   (SAEN_CSA),
        .CLK_EN_ADC (CLK_EN_ADC),
        .CSA        (CSA),
        .ADC_OUT0   (ADC_OUT0),
        .ADC_OUT1   (ADC_OUT1),
        .ADC_OUT2   (ADC_OUT2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] res;
        logic        mode;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   n_res   = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Issue a read at a negedge; the accepting edge is the next posedge.
    task automatic issue(input logic m, input logic [15:0] wl, input logic [47:0] res, input int lat);
        exp_t e;
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.wl_sel = wl;
        e.res  = res;
        e.mode = m;
        e.due  = cyc + 1 + lat - 1;
        q.push_back(e);
    endtask

    // Scoreboard monitor and pin invariants.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid <= 1'b0;
        end else begin
            chk("pre_excl_enable", 64'(PRE && (ENABLE_WL || ENABLE_BL || ENABLE_SL || ENABLE_CSA)), 64'd0);
            chk("in1_wl_zero", 64'(IN1_WL), 64'd0);
            if (bus.result_valid && !prev_valid) begin
                n_res++;
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(bus.result), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", 64'(bus.result), 64'(e.res));
                    chk("result_mode", 64'(bus.result_mode), 64'(e.mode));
                    chk("valid_latency", 64'(cyc), 64'(e.due));
                end
            end
            prev_valid <= bus.result_valid;
        end
    end

    initial begin
        bus.start        = 1'b0;
        bus.mode         = 1'b0;
        bus.wl_sel       = 16'h0000;
        bus.result_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_pre", 64'(PRE), 64'd0);
        chk("rst_clk_en_adc", 64'(CLK_EN_ADC), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // CSA read with pin timing.
        CSA = 16'hA5A5;
        issue(1'b0, 16'h0001, 48'h0000_0000_A5A5, 11);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("csa_pre", 64'(PRE), 64'(rng(c, 1, 4)));
            chk("csa_en_wl", 64'(ENABLE_WL), 64'(rng(c, 5, 10)));
            chk("csa_en_bl", 64'(ENABLE_BL), 64'(rng(c, 5, 10)));
            chk("csa_en_sl", 64'(ENABLE_SL), 64'(rng(c, 5, 10)));
            chk("csa_in0_wl", 64'(IN0_WL), rng(c, 5, 10) ? 64'h1 : 64'h0);
            chk("csa_saen", 64'(SAEN_CSA), 64'(rng(c, 8, 9)));
            chk("csa_en_csa", 64'(ENABLE_CSA), 64'(rng(c, 8, 10)));
            chk("csa_clk_en_adc", 64'(CLK_EN_ADC), 64'd0);
            chk("csa_valid", 64'(bus.result_valid), 64'(c == 11));
            chk("csa_busy", 64'(bus.busy), 64'd1);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("csa_done_busy", 64'(bus.busy), 64'd0);
        chk("csa_done_valid", 64'(bus.result_valid), 64'd0);

        // ADC read, then a long HOLD.
        ADC_OUT2 = 16'h00FF;
        ADC_OUT1 = 16'hF0F0;
        ADC_OUT0 = 16'h1234;
        issue(1'b1, 16'h8000, 48'h00FF_F0F0_1234, 17);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("adc_pre", 64'(PRE), 64'(rng(c, 1, 4)));
            chk("adc_en_sl", 64'(ENABLE_SL), 64'(rng(c, 5, 16)));
            chk("adc_in0_wl", 64'(IN0_WL), rng(c, 5, 16) ? 64'h8000 : 64'h0);
            chk("adc_clk_en", 64'(CLK_EN_ADC),
                rng(c, 8, 11) ? 64'd1 : (rng(c, 12, 15) ? 64'd2 : 64'd0));
            chk("adc_no_csa", 64'(ENABLE_CSA || SAEN_CSA), 64'd0);
            chk("adc_valid", 64'(bus.result_valid), 64'(c == 17));
        end
        ADC_OUT2 = 16'h1111;
        ADC_OUT1 = 16'h2222;
        ADC_OUT0 = 16'h3333;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.result_valid), 64'd1);
            chk("hold_result", 64'(bus.result), 64'h00FF_F0F0_1234);
            chk("hold_busy", 64'(bus.busy), 64'd1);
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("adc_done_busy", 64'(bus.busy), 64'd0);
        chk("adc_done_valid", 64'(bus.result_valid), 64'd0);
        chk("adc_result_kept", 64'(bus.result), 64'h00FF_F0F0_1234);

        // Rejected start.
        bus.start  = 1'b1;
        bus.wl_sel = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_pulse", 64'(bus.cmd_err), 64'd1);
        chk("err_busy", 64'(bus.busy), 64'd0);
        chk("err_pins", 64'({PRE, ENABLE_WL, ENABLE_CSA, SAEN_CSA, CLK_EN_ADC, IN0_WL}), 64'd0);
        @(negedge clk);
        chk("err_pulse_end", 64'(bus.cmd_err), 64'd0);
        chk("err_busy_end", 64'(bus.busy), 64'd0);

        // Starts during DRIVE and together with result_ready are ignored.
        CSA = 16'h3C3C;
        issue(1'b0, 16'h0F0F, 48'h0000_0000_3C3C, 11);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start = (c == 6);
            if (c == 6) begin
                bus.wl_sel = 16'hFFFF;
                bus.mode   = 1'b1;
            end
            if (rng(c, 7, 10)) begin
                chk("ign_in0_wl", 64'(IN0_WL), 64'h0F0F);
                chk("ign_no_adc", 64'(CLK_EN_ADC), 64'd0);
            end
        end
        bus.start        = 1'b1;
        bus.mode         = 1'b0;
        bus.wl_sel       = 16'h0002;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        chk("ign_busy0", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("ign_busy1", 64'(bus.busy), 64'd0);
        chk("ign_pre", 64'(PRE), 64'd0);

        // Reset in the middle of an ADC conversion.
        issue(1'b1, 16'h0100, 48'h0, 17);
        void'(q.pop_back());
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("mid_clk_en_before", 64'(CLK_EN_ADC), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_clk_en", 64'(CLK_EN_ADC), 64'd0);
        chk("mid_rst_en", 64'({ENABLE_WL, ENABLE_BL, ENABLE_SL}), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_in0", 64'(IN0_WL), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fresh CSA read after reset.
        CSA = 16'h5A0F;
        issue(1'b0, 16'h0040, 48'h0000_0000_5A0F, 11);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("post_rst_valid", 64'(bus.result_valid), 64'd1);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk("post_rst_busy", 64'(bus.busy), 64'd0);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("result_count", 64'(n_res), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
